// File: rtl/uart_decode.sv
// uart_decode: UART frame receiver that assembles bytes into PACKET_SIZE-bit packets.
// Frame on the line (LSB first): start=1, data[0..7], parity=^data, stop=1; the idle level is 0.
// Compile-time option: define UART_DECODE_PARITY_EN to enable parity checking.
// Without it, the parity bit is skipped and parity_err stays at 0.
//
// state  | meaning
// ARM    | wait for the line to read 0 before a start edge is trusted
// IDLE   | line is known low; a 0->1 edge begins a frame
// START  | half a bit in, confirm the start bit (a low sample means a glitch)
// DATA   | sample 8 data bits, one per bit time, LSB first
// PARITY | sample the parity bit
// STOP   | sample the stop bit, then accept or discard the byte
module uart_decode #(
  parameter int PACKET_SIZE  = 32,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx,
  output logic [PACKET_SIZE-1:0] sys_packet,
  output logic                   packet_valid,
  input  logic                   packet_ready,
  output logic                   parity_err,
  output logic                   framing_err,
  output logic                   overrun
);

  localparam int NUM_BYTES = PACKET_SIZE / 8;
  localparam int CNT_W     = $clog2(NUM_BYTES + 1);
  localparam int TMR_W     = $clog2(CLKS_PER_BIT);

  localparam logic [TMR_W-1:0] TMR_FULL  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] TMR_HALF  = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] TMR_ZERO  = '0;
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    ARM    = 3'd0,
    IDLE   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t                 state;
  logic                   rx_meta;
  logic                   rx_sync;
  logic                   rx_prev;
  logic [TMR_W-1:0]       timer;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;
  logic                   byte_ok;
  logic                   byte_bad;
  logic [CNT_W-1:0]       byte_cnt;
  logic [PACKET_SIZE-1:0] assembly;
  logic [PACKET_SIZE-1:0] asm_next;
  logic                   pkt_done;

`ifdef UART_DECODE_PARITY_EN
  logic                   par_bit;
`else
  assign parity_err = 1'b0;
`endif

  // Two-flop synchronizer for the asynchronous line, plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Frame FSM: down-counting bit timer, data shift register and per-byte verdict pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARM;
      timer       <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      byte_ok     <= 1'b0;
      byte_bad    <= 1'b0;
      framing_err <= 1'b0;
`ifdef UART_DECODE_PARITY_EN
      par_bit     <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      byte_ok     <= 1'b0;
      byte_bad    <= 1'b0;
      framing_err <= 1'b0;
`ifdef UART_DECODE_PARITY_EN
      parity_err  <= 1'b0;
`endif
      case (state)
        ARM: begin
          if (!rx_sync) state <= IDLE;
        end
        IDLE: begin
          if (rx_sync && !rx_prev) begin
            state   <= START;
            timer   <= TMR_HALF;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (timer != TMR_ZERO) begin
            timer <= timer - TMR_ONE;
          end else if (rx_sync) begin
            state <= DATA;
            timer <= TMR_FULL;
          end else begin
            // Start bit did not hold for half a bit: a glitch, not a frame.
            state <= IDLE;
          end
        end
        DATA: begin
          if (timer != TMR_ZERO) begin
            timer <= timer - TMR_ONE;
          end else begin
            shift <= {rx_sync, shift[7:1]};
            timer <= TMR_FULL;
            if (bit_cnt == 3'd7) begin
              state   <= PARITY;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        PARITY: begin
          if (timer != TMR_ZERO) begin
            timer <= timer - TMR_ONE;
          end else begin
`ifdef UART_DECODE_PARITY_EN
            par_bit <= rx_sync;
`endif
            timer <= TMR_FULL;
            state <= STOP;
          end
        end
        STOP: begin
          if (timer != TMR_ZERO) begin
            timer <= timer - TMR_ONE;
          end else begin
            state <= ARM;
            if (!rx_sync) begin
              framing_err <= 1'b1;
              byte_bad    <= 1'b1;
            end
`ifdef UART_DECODE_PARITY_EN
            else if (par_bit != (^shift)) begin
              parity_err <= 1'b1;
              byte_bad   <= 1'b1;
            end
`endif
            else begin
              byte_ok <= 1'b1;
            end
          end
        end
        default: state <= ARM;
      endcase
    end
  end

  // Bytes arrive first-to-last, so shifting left and inserting at the bottom
  // leaves byte 0 in the top byte lane once the packet is complete.
  generate
    if (NUM_BYTES == 1) begin : g_single
      assign asm_next = shift;
    end else begin : g_multi
      assign asm_next = {assembly[PACKET_SIZE-9:0], shift};
    end
  endgenerate

  // Packet assembly: collect accepted bytes, drop the partial packet on a bad byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      assembly <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      if (byte_bad) begin
        byte_cnt <= '0;
      end else if (byte_ok) begin
        assembly <= asm_next;
        if (byte_cnt == LAST_BYTE) begin
          byte_cnt <= '0;
          pkt_done <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + CNT_ONE;
        end
      end
    end
  end

  // Output handshake: hold the packet until consumed; a completion that finds it unconsumed is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sys_packet   <= '0;
      packet_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (pkt_done) begin
        if (!packet_valid || packet_ready) begin
          sys_packet   <= assembly;
          packet_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (packet_valid && packet_ready) begin
        packet_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_decode.sv
// Directed bench for uart_decode: stimulus pushes expected packets, a monitor
// pops and compares them on each valid/ready handshake.
module tb_uart_decode;

  localparam int PS  = 32;
  localparam int CPB = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b0;
  logic          packet_ready = 1'b1;
  logic [PS-1:0] sys_packet;
  logic          packet_valid;
  logic          parity_err;
  logic          framing_err;
  logic          overrun;

  uart_decode #(.PACKET_SIZE(PS), .CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .sys_packet   (sys_packet),
    .packet_valid (packet_valid),
    .packet_ready (packet_ready),
    .parity_err   (parity_err),
    .framing_err  (framing_err),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_par = 0;
  int n_frm = 0;
  int n_ovr = 0;
  int n_vcyc = 0;
  int t_rise = 0;
  logic valid_q = 1'b0;
  logic [PS-1:0] sb[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pulse counters and scoreboard compare on every handshake.
  always @(negedge clk) begin
    logic [PS-1:0] exp_pkt;
    if (packet_valid) n_vcyc++;
    if (packet_valid && !valid_q) t_rise = cyc;
    valid_q = packet_valid;
    if (parity_err) n_par++;
    if (framing_err) n_frm++;
    if (overrun) n_ovr++;
    if (packet_valid && packet_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL packet: got unexpected %0h, expected none", sys_packet);
      end else begin
        exp_pkt = sb.pop_front();
        check("packet", {32'd0, sys_packet}, {32'd0, exp_pkt});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One frame: start, 8 data bits LSB first, parity (optionally inverted), stop, then idle gap.
  task automatic send_frame(input logic [7:0] d, input bit pflip, input bit sbit, output int t_start);
    logic [10:0] f;
    f = {sbit, (^d) ^ pflip, d, 1'b1};
    t_start = cyc;
    for (int i = 0; i < 11; i++) begin
      rx = f[i];
      tick(CPB);
    end
    rx = 1'b0;
    tick(20);
  endtask

  initial begin
    int t0;
    int p0, f0, o0, v0;

    rst_n = 1'b0;
    rx = 1'b0;
    packet_ready = 1'b1;
    tick(5);
    check("reset sys_packet", {32'd0, sys_packet}, 64'd0);
    check("reset valid", {63'd0, packet_valid}, 64'd0);
    check("reset pulses", {61'd0, parity_err, framing_err, overrun}, 64'd0);
    rst_n = 1'b1;
    tick(3);

    // Basic packet with ready held high.
    p0 = n_par; f0 = n_frm; o0 = n_ovr; v0 = n_vcyc;
    send_frame(8'hDE, 0, 1, t0);
    send_frame(8'hAD, 0, 1, t0);
    send_frame(8'hBE, 0, 1, t0);
    sb.push_back(32'hDEADBEEF);
    send_frame(8'hEF, 0, 1, t0);
    tick(20);
    check("basic valid cycles", 64'(n_vcyc - v0), 64'd1);
    check("basic latency", 64'(t_rise - t0), 64'd173);
    check("basic err pulses", 64'((n_par - p0) + (n_frm - f0) + (n_ovr - o0)), 64'd0);
    check("basic drained", 64'(sb.size()), 64'd0);

    // Inverted parity on 0x55.
    p0 = n_par; f0 = n_frm;
`ifdef UART_DECODE_PARITY_EN
    send_frame(8'h55, 1, 1, t0);
    send_frame(8'h11, 0, 1, t0);
    send_frame(8'h22, 0, 1, t0);
    send_frame(8'h33, 0, 1, t0);
    sb.push_back(32'h11223344);
    send_frame(8'h44, 0, 1, t0);
    tick(20);
    check("parity err pulses", 64'(n_par - p0), 64'd1);
`else
    send_frame(8'h55, 1, 1, t0);
    send_frame(8'h11, 0, 1, t0);
    send_frame(8'h22, 0, 1, t0);
    sb.push_back(32'h55112233);
    send_frame(8'h33, 0, 1, t0);
    tick(20);
    check("parity err pulses", 64'(n_par - p0), 64'd0);
`endif
    check("parity framing pulses", 64'(n_frm - f0), 64'd0);
    check("parity drained", 64'(sb.size()), 64'd0);

    // Bad stop bit after two good bytes.
    p0 = n_par; f0 = n_frm;
    send_frame(8'hAA, 0, 1, t0);
    send_frame(8'hBB, 0, 1, t0);
    send_frame(8'hCC, 0, 0, t0);
    send_frame(8'h01, 0, 1, t0);
    send_frame(8'h02, 0, 1, t0);
    send_frame(8'h03, 0, 1, t0);
    sb.push_back(32'h01020304);
    send_frame(8'h04, 0, 1, t0);
    tick(20);
    check("framing err pulses", 64'(n_frm - f0), 64'd1);
    check("framing parity pulses", 64'(n_par - p0), 64'd0);
    check("framing drained", 64'(sb.size()), 64'd0);

    // Overrun: consumer stalled across two packets.
    o0 = n_ovr;
    packet_ready = 1'b0;
    send_frame(8'h10, 0, 1, t0);
    send_frame(8'h11, 0, 1, t0);
    send_frame(8'h12, 0, 1, t0);
    sb.push_back(32'h10111213);
    send_frame(8'h13, 0, 1, t0);
    send_frame(8'h14, 0, 1, t0);
    send_frame(8'h15, 0, 1, t0);
    send_frame(8'h16, 0, 1, t0);
    send_frame(8'h17, 0, 1, t0);
    tick(20);
    check("overrun pulses", 64'(n_ovr - o0), 64'd1);
    check("overrun held valid", {63'd0, packet_valid}, 64'd1);
    check("overrun held packet", {32'd0, sys_packet}, 64'h10111213);
    packet_ready = 1'b1;
    tick(1);
    check("overrun valid drop", {63'd0, packet_valid}, 64'd0);
    check("overrun drained", 64'(sb.size()), 64'd0);

    // Short high glitch on an idle line.
    p0 = n_par; f0 = n_frm; o0 = n_ovr; v0 = n_vcyc;
    rx = 1'b1;
    tick(3);
    rx = 1'b0;
    tick(40);
    check("glitch pulses", 64'((n_par - p0) + (n_frm - f0) + (n_ovr - o0)), 64'd0);
    check("glitch valid cycles", 64'(n_vcyc - v0), 64'd0);
    check("glitch packet", {32'd0, sys_packet}, 64'h10111213);

    // Reset in the middle of byte 2, then a fresh packet.
    send_frame(8'h99, 0, 1, t0);
    rx = 1'b1;
    tick(CPB);
    rx = 1'b0;
    tick(3 * CPB);
    rst_n = 1'b0;
    tick(3);
    check("midreset sys_packet", {32'd0, sys_packet}, 64'd0);
    check("midreset valid", {63'd0, packet_valid}, 64'd0);
    rst_n = 1'b1;
    tick(5);
    p0 = n_par; f0 = n_frm; o0 = n_ovr;
    send_frame(8'hC0, 0, 1, t0);
    send_frame(8'hFF, 0, 1, t0);
    send_frame(8'hEE, 0, 1, t0);
    sb.push_back(32'hC0FFEE42);
    send_frame(8'h42, 0, 1, t0);
    tick(20);
    check("post-reset pulses", 64'((n_par - p0) + (n_frm - f0) + (n_ovr - o0)), 64'd0);
    check("post-reset drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
